// File: rtl/vic_pkg.sv
// vic_pkg: shared constants and FSM state type for the interrupt source block
package vic_pkg;
  localparam int N_IRQ = 32;
  localparam int ISR_ADDR_W = 5;
  localparam int ACK_TIMEOUT_DEF = 16;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE, GAP} vic_state_e;
endpackage

// File: rtl/vic_irq_src_if.sv
// vic_irq_src_if: peripheral, mask and controller handshake signals of the interrupt source
interface vic_irq_src_if;
  import vic_pkg::*;
  logic [N_IRQ-1:0]      i_irq_lines;
  logic                  i_mask_we;
  logic [N_IRQ-1:0]      i_mask_wdata;
  logic                  i_IRQ_VIC;
  logic                  i_reti;
  logic                  o_IRQ;
  logic [ISR_ADDR_W-1:0] o_ISR_addr;
  logic [N_IRQ-1:0]      o_pending;
  logic [N_IRQ-1:0]      o_mask;
  logic                  o_busy;
  modport slave (
    input  i_irq_lines, i_mask_we, i_mask_wdata, i_IRQ_VIC, i_reti,
    output o_IRQ, o_ISR_addr, o_pending, o_mask, o_busy
  );
  modport master (
    output i_irq_lines, i_mask_we, i_mask_wdata, i_IRQ_VIC, i_reti,
    input  o_IRQ, o_ISR_addr, o_pending, o_mask, o_busy
  );
endinterface

// File: rtl/vic_prio_enc.sv
// vic_prio_enc: lowest-index-first priority encoder with valid flag
module vic_prio_enc
  import vic_pkg::*;
(
  input  logic [N_IRQ-1:0]      req_i,
  output logic [ISR_ADDR_W-1:0] idx_o,
  output logic                  valid_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (req_i[i]) idx_o = ISR_ADDR_W'(i);
  end
  assign valid_o = |req_i;
endmodule

// File: rtl/vic_irq_src.sv
// vic_irq_src: edge-latching interrupt source with mask, priority arbitration,
// acknowledge timeout/retry and tail-chaining towards a vectored controller
module vic_irq_src
  import vic_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  vic_irq_src_if.slave bus
);
  vic_state_e            state_q, state_d;
  logic                  irq_q, irq_d;
  logic [ISR_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [N_IRQ-1:0]      pend_q, prev_q, mask_q, clr;
  logic [SYNC_STAGES-1:0] vic_sync_q, reti_sync_q;
  logic                  reti_last_q;
  logic [N_IRQ-1:0]      arb_req;
  logic [ISR_ADDR_W-1:0] arb_idx;
  logic                  arb_vld, ack, reti_rise;

  assign arb_req   = pend_q & mask_q;
  assign ack       = vic_sync_q[SYNC_STAGES-1];
  assign reti_rise = reti_sync_q[SYNC_STAGES-1] & ~reti_last_q;

  vic_prio_enc u_enc (.req_i(arb_req), .idx_o(arb_idx), .valid_o(arb_vld));

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    clr     = '0;
    case (state_q)
      IDLE: if (arb_vld) begin
        state_d = REQ;
        irq_d   = 1'b1;
        addr_d  = arb_idx;
        cnt_d   = '0;
      end
      REQ: if (ack) begin
        clr     = N_IRQ'(1) << addr_q;
        irq_d   = 1'b0;
        state_d = SERVICE;
      end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
        irq_d   = 1'b0;
        state_d = GAP;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
      // Tail-chain re-arbitrates on the reti edge, skipping GAP/IDLE.
      SERVICE: if (reti_rise) begin
        state_d = arb_vld ? REQ : GAP;
        irq_d   = arb_vld;
        addr_d  = arb_vld ? arb_idx : addr_q;
        cnt_d   = '0;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      irq_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      prev_q      <= '0;
      mask_q      <= '0;
      vic_sync_q  <= '0;
      reti_sync_q <= '0;
      reti_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      prev_q      <= bus.i_irq_lines;
      pend_q      <= (pend_q & ~clr) | (bus.i_irq_lines & ~prev_q);
      if (bus.i_mask_we) mask_q <= bus.i_mask_wdata;
      vic_sync_q  <= {vic_sync_q[SYNC_STAGES-2:0], bus.i_IRQ_VIC};
      reti_sync_q <= {reti_sync_q[SYNC_STAGES-2:0], bus.i_reti};
      reti_last_q <= reti_sync_q[SYNC_STAGES-1];
    end
  end

  assign bus.o_IRQ      = irq_q;
  assign bus.o_ISR_addr = addr_q;
  assign bus.o_pending  = pend_q;
  assign bus.o_mask     = mask_q;
  assign bus.o_busy     = state_q != IDLE;
endmodule

// File: tb/tb_vic_irq_src.sv
// tb_vic_irq_src: table-driven cycle vectors plus directed timeout, reset and set-wins sequences
module tb_vic_irq_src;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  vic_irq_src_if bus ();
  vic_irq_src #(.ACK_TIMEOUT(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lines;
    logic        we;
    logic [31:0] wd;
    logic        vic;
    logic        reti;
    logic        irq;
    logic [4:0]  addr;
    logic [31:0] pend;
    logic        busy;
    logic [31:0] mask;
  } vec_t;

  vec_t tbl[33];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi;
    logic [31:0] ff;
    ff = 32'hFFFF_FFFF;
    //              lines      we wd            vic  reti irq  addr  pend       busy mask
    tbl[0]  = '{32'h0,      1, ff,           0,   0,   0,   0,    32'h0,     0,   ff};
    tbl[1]  = '{32'h8,      0, 0,            0,   0,   0,   0,    32'h8,     0,   ff};
    tbl[2]  = '{32'h8,      0, 0,            0,   0,   1,   3,    32'h8,     1,   ff};
    tbl[3]  = '{32'h8,      0, 0,            1,   0,   1,   3,    32'h8,     1,   ff};
    tbl[4]  = '{32'h8,      0, 0,            1,   0,   1,   3,    32'h8,     1,   ff};
    tbl[5]  = '{32'h8,      0, 0,            1,   0,   0,   3,    32'h0,     1,   ff};
    tbl[6]  = '{32'h0,      0, 0,            0,   0,   0,   3,    32'h0,     1,   ff};
    tbl[7]  = '{32'h0,      0, 0,            0,   1,   0,   3,    32'h0,     1,   ff};
    tbl[8]  = '{32'h0,      0, 0,            0,   1,   0,   3,    32'h0,     1,   ff};
    tbl[9]  = '{32'h0,      0, 0,            0,   1,   0,   3,    32'h0,     1,   ff};
    tbl[10] = '{32'h0,      0, 0,            0,   0,   0,   3,    32'h0,     0,   ff};
    tbl[11] = '{32'h84,     0, 0,            0,   0,   0,   3,    32'h84,    0,   ff};
    tbl[12] = '{32'h84,     0, 0,            0,   0,   1,   2,    32'h84,    1,   ff};
    tbl[13] = '{32'h84,     0, 0,            1,   0,   1,   2,    32'h84,    1,   ff};
    tbl[14] = '{32'h84,     0, 0,            1,   0,   1,   2,    32'h84,    1,   ff};
    tbl[15] = '{32'h84,     0, 0,            1,   0,   0,   2,    32'h80,    1,   ff};
    tbl[16] = '{32'h84,     0, 0,            0,   0,   0,   2,    32'h80,    1,   ff};
    tbl[17] = '{32'h84,     0, 0,            0,   1,   0,   2,    32'h80,    1,   ff};
    tbl[18] = '{32'h84,     0, 0,            0,   1,   0,   2,    32'h80,    1,   ff};
    tbl[19] = '{32'h84,     0, 0,            0,   1,   1,   7,    32'h80,    1,   ff};
    tbl[20] = '{32'h84,     0, 0,            0,   0,   1,   7,    32'h80,    1,   ff};
    tbl[21] = '{32'h0,      0, 0,            1,   0,   1,   7,    32'h80,    1,   ff};
    tbl[22] = '{32'h0,      0, 0,            1,   0,   1,   7,    32'h80,    1,   ff};
    tbl[23] = '{32'h0,      0, 0,            1,   0,   0,   7,    32'h0,     1,   ff};
    tbl[24] = '{32'h0,      0, 0,            0,   1,   0,   7,    32'h0,     1,   ff};
    tbl[25] = '{32'h0,      0, 0,            0,   1,   0,   7,    32'h0,     1,   ff};
    tbl[26] = '{32'h0,      0, 0,            0,   1,   0,   7,    32'h0,     1,   ff};
    tbl[27] = '{32'h0,      0, 0,            0,   0,   0,   7,    32'h0,     0,   ff};
    tbl[28] = '{32'h0,      1, 32'h0,        0,   0,   0,   7,    32'h0,     0,   32'h0};
    tbl[29] = '{32'h20,     0, 0,            0,   0,   0,   7,    32'h20,    0,   32'h0};
    tbl[30] = '{32'h20,     0, 0,            0,   0,   0,   7,    32'h20,    0,   32'h0};
    tbl[31] = '{32'h20,     1, 32'h20,       0,   0,   0,   7,    32'h20,    0,   32'h20};
    tbl[32] = '{32'h20,     0, 0,            0,   0,   1,   5,    32'h20,    1,   32'h20};

    bus.i_irq_lines = '0; bus.i_mask_we = 0; bus.i_mask_wdata = '0;
    bus.i_IRQ_VIC = 0; bus.i_reti = 0;
    repeat (2) tick();
    chk("rst_irq", 32'(bus.o_IRQ), 0);
    chk("rst_addr", 32'(bus.o_ISR_addr), 0);
    chk("rst_pend", bus.o_pending, 0);
    chk("rst_mask", bus.o_mask, 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    rst = 1'b1;

    for (int i = 0; i < 33; i++) begin
      bus.i_irq_lines = tbl[i].lines; bus.i_mask_we = tbl[i].we; bus.i_mask_wdata = tbl[i].wd;
      bus.i_IRQ_VIC = tbl[i].vic; bus.i_reti = tbl[i].reti;
      tick();
      chk($sformatf("v%0d_irq", i), 32'(bus.o_IRQ), 32'(tbl[i].irq));
      chk($sformatf("v%0d_addr", i), 32'(bus.o_ISR_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_pend", i), bus.o_pending, tbl[i].pend);
      chk($sformatf("v%0d_busy", i), 32'(bus.o_busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_mask", i), bus.o_mask, tbl[i].mask);
    end

    bus.i_mask_we = 0;
    hi = 0;
    for (int k = 0; k < 40 && bus.o_IRQ; k++) begin
      hi++;
      tick();
    end
    chk("to_high_cycles", 32'(hi), 16);
    chk("to_gap_irq", 32'(bus.o_IRQ), 0);
    chk("to_gap_busy", 32'(bus.o_busy), 1);
    chk("to_gap_pend", bus.o_pending, 32'h20);
    tick();
    chk("to_idle_irq", 32'(bus.o_IRQ), 0);
    chk("to_idle_busy", 32'(bus.o_busy), 0);
    tick();
    chk("to_retry_irq", 32'(bus.o_IRQ), 1);
    chk("to_retry_addr", 32'(bus.o_ISR_addr), 5);

    #1 rst = 1'b0;
    #1;
    chk("arst_irq", 32'(bus.o_IRQ), 0);
    chk("arst_pend", bus.o_pending, 0);
    chk("arst_mask", bus.o_mask, 0);
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_addr", 32'(bus.o_ISR_addr), 0);
    bus.i_irq_lines = '0;
    #1 rst = 1'b1;

    bus.i_mask_we = 1; bus.i_mask_wdata = ff;
    tick();
    bus.i_mask_we = 0; bus.i_irq_lines = 32'h10;
    tick();
    chk("sw_pend_set", bus.o_pending, 32'h10);
    tick();
    chk("sw_req_irq", 32'(bus.o_IRQ), 1);
    chk("sw_req_addr", 32'(bus.o_ISR_addr), 4);
    bus.i_IRQ_VIC = 1;
    tick();
    bus.i_irq_lines = '0;
    tick();
    bus.i_irq_lines = 32'h10;
    tick();
    chk("sw_ack_irq", 32'(bus.o_IRQ), 0);
    chk("sw_set_wins", bus.o_pending, 32'h10);
    chk("sw_busy", 32'(bus.o_busy), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
